// File: rtl/complex_div_if.sv
// Operand/result handshake bundle for the sequential complex divider.
// The slave side is the divider; the master side is whoever feeds and drains it.
interface complex_div_if #(
   parameter int WIDTH = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] real_in;
   logic signed [WIDTH-1:0] complex_in;
   logic signed [WIDTH-1:0] div_real;
   logic signed [WIDTH-1:0] div_complex;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] R_out;
   logic signed [WIDTH-1:0] C_out;
   logic                    div_by_zero;

   modport master (
      output in_valid, real_in, complex_in, div_real, div_complex, out_ready,
      input  in_ready, out_valid, R_out, C_out, div_by_zero
   );

   modport slave (
      input  in_valid, real_in, complex_in, div_real, div_complex, out_ready,
      output in_ready, out_valid, R_out, C_out, div_by_zero
   );
endinterface

// File: rtl/complex_div.sv
// Sequential Q1.15 complex divider: (a+jb)/(c+jd) via conjugate multiply and
// two restoring-division lanes sharing one denominator c^2+d^2.

// One restoring-division lane: shifts the remainder left and subtracts den.
module complex_div_lane #(
   parameter int DW   = 33,
   parameter int FRAC = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic [DW-1:0]   mag,
   input  logic [DW-1:0]   den,
   output logic [FRAC-1:0] quo
);
   logic [DW:0] rem, sh;
   logic        ge;

   always_comb begin
      sh = rem << 1;
      ge = (sh >= {1'b0, den});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
         quo <= '0;
      end else if (load) begin
         rem <= {1'b0, mag};
         quo <= '0;
      end else if (step) begin
         rem <= ge ? (sh - {1'b0, den}) : sh;
         quo <= {quo[FRAC-2:0], ge};
      end
   end
endmodule

module complex_div #(
   parameter int WIDTH = 16,
   parameter int FRAC  = WIDTH - 1
) (
   input logic          clk,
   input logic          rst_n,
   complex_div_if.slave bus
);
   localparam int PW    = 2 * WIDTH;
   localparam int DW    = PW + 1;
   localparam int LANES = 2;
   localparam int CW    = $clog2(FRAC + 1);
   localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAXN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;
   typedef struct packed {
      logic signed [WIDTH-1:0] a;
      logic signed [WIDTH-1:0] b;
      logic signed [WIDTH-1:0] c;
      logic signed [WIDTH-1:0] d;
   } req_t;

   state_t state, state_n;
   req_t   op;
   logic [CW-1:0] cnt;
   logic accept, load, step, fin;

   logic signed [PW-1:0] ac, bd, bc, ad, cc, dd;
   logic signed [DW-1:0] nr, ni;
   logic [DW-1:0] den_w, den_q;
   logic dz;
   logic [LANES-1:0]            sgn, sat;
   logic [LANES-1:0][DW-1:0]    mag;
   logic [LANES-1:0][FRAC-1:0]  quo;
   logic [LANES-1:0][WIDTH-1:0] res;
   logic [WIDTH-1:0]            qx;

   // Multiply by the conjugate so only a real denominator is left to divide by.
   always_comb begin
      ac     = PW'(op.a) * PW'(op.c);
      bd     = PW'(op.b) * PW'(op.d);
      bc     = PW'(op.b) * PW'(op.c);
      ad     = PW'(op.a) * PW'(op.d);
      cc     = PW'(op.c) * PW'(op.c);
      dd     = PW'(op.d) * PW'(op.d);
      nr     = DW'(ac) + DW'(bd);
      ni     = DW'(bc) - DW'(ad);
      den_w  = DW'($unsigned(cc)) + DW'($unsigned(dd));
      mag[0] = nr[DW-1] ? $unsigned(-nr) : $unsigned(nr);
      mag[1] = ni[DW-1] ? $unsigned(-ni) : $unsigned(ni);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // DIV runs FRAC steps, then spends one more cycle formatting the result.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      case (state)
         IDLE: if (bus.in_valid) begin
            accept  = 1'b1;
            state_n = PREP;
         end
         PREP: begin
            load    = 1'b1;
            state_n = DIV;
         end
         DIV: if (cnt == CW'(FRAC)) begin
            fin     = 1'b1;
            state_n = DONE;
         end else begin
            step = 1'b1;
         end
         DONE: if (bus.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      complex_div_lane #(.DW(DW), .FRAC(FRAC)) u_lane (
         .clk  (clk),
         .rst_n(rst_n),
         .load (load),
         .step (step),
         .mag  (mag[i]),
         .den  (den_q),
         .quo  (quo[i])
      );
   end

   always_comb begin
      res = '0;
      qx  = '0;
      for (int i = 0; i < LANES; i++) begin
         qx = WIDTH'(quo[i]);
         if (dz)          res[i] = '0;
         else if (sat[i]) res[i] = sgn[i] ? MAXN : MAXP;
         else             res[i] = sgn[i] ? -qx : qx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op              <= '0;
         cnt             <= '0;
         sgn             <= '0;
         sat             <= '0;
         den_q           <= '0;
         dz              <= 1'b0;
         bus.R_out       <= '0;
         bus.C_out       <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         if (accept) op <= {bus.real_in, bus.complex_in, bus.div_real, bus.div_complex};
         if (load) begin
            cnt    <= '0;
            sgn    <= {ni[DW-1], nr[DW-1]};
            sat[0] <= (mag[0] >= den_w);
            sat[1] <= (mag[1] >= den_w);
            den_q  <= den_w;
            dz     <= (den_w == '0);
         end else if (step) begin
            cnt <= cnt + 1'b1;
         end
         if (fin) begin
            bus.R_out       <= res[0];
            bus.C_out       <= res[1];
            bus.div_by_zero <= dz;
         end
      end
   end
endmodule
